fb_write_seq: RTL

- Write-side sequencer for the R/G/B frame buffers.
- Produces one pixel write per clock: clear-to-black sweeps of the whole frame after reset or on request, and square brush stamps at the cursor in the current paint colour.
- Sits between the cursor/colour control logic (upstream) and the three buffer instances (downstream); replaces separate clear and cursor-paint address generators.

---
 rtl/fb_write_seq.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/fb_write_seq.sv
// Frame-buffer write sequencer: full-frame clear sweeps and square brush stamps, one pixel per clock.
// All outputs are registered; brush pixels outside the frame consume a cycle with the write enable low.
module fb_write_seq #(
  parameter int W_RES = 640,
  parameter int H_RES = 480
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_paint_en,
  input  logic        i_clear_req,
  input  logic [10:0] i_cursor_x,
  input  logic [10:0] i_cursor_y,
  input  logic [6:0]  i_size,
  input  logic [7:0]  i_color_r,
  input  logic [7:0]  i_color_g,
  input  logic [7:0]  i_color_b,
  output logic        o_wr_en,
  output logic [10:0] o_wr_x,
  output logic [10:0] o_wr_y,
  output logic [7:0]  o_wr_r,
  output logic [7:0]  o_wr_g,
  output logic [7:0]  o_wr_b,
  output logic        o_busy,
  output logic        o_clear_done
);
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_PAINT} state_t;

  localparam logic [10:0] X_LAST = 11'(W_RES - 1);
  localparam logic [10:0] Y_END  = 11'(H_RES);

  state_t      r_state, w_state_nxt;
  logic [10:0] r_clr_x, r_clr_y;
  logic [6:0]  r_dx, r_dy, r_size;
  logic [10:0] r_cx, r_cy;
  logic [7:0]  r_col_r, r_col_g, r_col_b;
  logic        r_pend;
  logic        r_wr_en, r_busy, r_clear_done;
  logic [10:0] r_wr_x, r_wr_y;
  logic [7:0]  r_wr_r, r_wr_g, r_wr_b;

  logic        w_clr_done, w_stamp_last, w_px_in;
  logic [6:0]  w_size_eff, w_dx_nxt, w_dy_nxt, w_off_x, w_off_y;
  logic [10:0] w_base_x, w_base_y;
  logic [11:0] w_px_x, w_px_y;
  logic [7:0]  w_col_r, w_col_g, w_col_b;
  logic        w_wr_en, w_busy, w_clear_done;
  logic [10:0] w_wr_x, w_wr_y;
  logic [7:0]  w_wr_r, w_wr_g, w_wr_b;

  // The clear sweep is finished once the row counter has stepped past the last row.
  assign w_clr_done   = (r_clr_y == Y_END);
  assign w_stamp_last = (r_dx == r_size - 7'd1) && (r_dy == r_size - 7'd1);
  assign w_size_eff   = (i_size == 7'd0) ? 7'd1 : i_size;
  assign w_dx_nxt     = (r_dx == r_size - 7'd1) ? 7'd0 : r_dx + 7'd1;
  assign w_dy_nxt     = (r_dx == r_size - 7'd1) ? r_dy + 7'd1 : r_dy;

  // Entering PAINT emits pixel (0,0) straight from the inputs being latched.
  assign w_base_x = (r_state == S_IDLE) ? i_cursor_x : r_cx;
  assign w_base_y = (r_state == S_IDLE) ? i_cursor_y : r_cy;
  assign w_off_x  = (r_state == S_IDLE) ? 7'd0 : w_dx_nxt;
  assign w_off_y  = (r_state == S_IDLE) ? 7'd0 : w_dy_nxt;
  assign w_col_r  = (r_state == S_IDLE) ? i_color_r : r_col_r;
  assign w_col_g  = (r_state == S_IDLE) ? i_color_g : r_col_g;
  assign w_col_b  = (r_state == S_IDLE) ? i_color_b : r_col_b;
  assign w_px_x   = {1'b0, w_base_x} + {5'd0, w_off_x};
  assign w_px_y   = {1'b0, w_base_y} + {5'd0, w_off_y};
  assign w_px_in  = (w_px_x < 12'(W_RES)) && (w_px_y < 12'(H_RES));

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state <= S_CLEAR;
      r_clr_x <= '0;  r_clr_y <= '0;
      r_dx    <= '0;  r_dy    <= '0;  r_size <= 7'd1;
      r_cx    <= '0;  r_cy    <= '0;
      r_col_r <= '0;  r_col_g <= '0;  r_col_b <= '0;
      r_pend  <= 1'b0;
      r_wr_en <= 1'b0; r_wr_x <= '0; r_wr_y <= '0;
      r_wr_r  <= '0;   r_wr_g <= '0; r_wr_b <= '0;
      r_busy  <= 1'b1; r_clear_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wr_en <= w_wr_en; r_wr_x <= w_wr_x; r_wr_y <= w_wr_y;
      r_wr_r  <= w_wr_r;  r_wr_g <= w_wr_g; r_wr_b <= w_wr_b;
      r_busy  <= w_busy;  r_clear_done <= w_clear_done;
      case (r_state)
        S_IDLE: begin
          if (w_state_nxt == S_CLEAR) begin
            r_pend  <= 1'b0;
            r_clr_x <= '0;
            r_clr_y <= '0;
          end else if (w_state_nxt == S_PAINT) begin
            r_cx    <= i_cursor_x; r_cy    <= i_cursor_y; r_size  <= w_size_eff;
            r_col_r <= i_color_r;  r_col_g <= i_color_g;  r_col_b <= i_color_b;
            r_dx    <= '0;         r_dy    <= '0;
          end
        end
        S_CLEAR: begin
          if (!w_clr_done) begin
            if (r_clr_x == X_LAST) begin
              r_clr_x <= '0;
              r_clr_y <= r_clr_y + 11'd1;
            end else begin
              r_clr_x <= r_clr_x + 11'd1;
            end
          end
        end
        S_PAINT: begin
          if (i_clear_req) r_pend <= 1'b1;
          if (!w_stamp_last) begin
            r_dx <= w_dx_nxt;
            r_dy <= w_dy_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_clear_req || r_pend) w_state_nxt = S_CLEAR;
        else if (i_paint_en)       w_state_nxt = S_PAINT;
      end
      S_CLEAR: if (w_clr_done)   w_state_nxt = S_IDLE;
      S_PAINT: if (w_stamp_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_wr_en      = 1'b0;
    w_wr_x       = r_wr_x;
    w_wr_y       = r_wr_y;
    w_wr_r       = r_wr_r;
    w_wr_g       = r_wr_g;
    w_wr_b       = r_wr_b;
    w_clear_done = 1'b0;
    w_busy       = (w_state_nxt != S_IDLE);
    if (r_state == S_CLEAR) begin
      if (w_clr_done) begin
        w_clear_done = 1'b1;
      end else begin
        w_wr_en = 1'b1;
        w_wr_x  = r_clr_x;
        w_wr_y  = r_clr_y;
        w_wr_r  = '0;
        w_wr_g  = '0;
        w_wr_b  = '0;
      end
    end else if (w_state_nxt == S_PAINT) begin
      w_wr_en = w_px_in;
      w_wr_x  = w_px_x[10:0];
      w_wr_y  = w_px_y[10:0];
      w_wr_r  = w_col_r;
      w_wr_g  = w_col_g;
      w_wr_b  = w_col_b;
    end
  end

  assign o_wr_en      = r_wr_en;
  assign o_wr_x       = r_wr_x;
  assign o_wr_y       = r_wr_y;
  assign o_wr_r       = r_wr_r;
  assign o_wr_g       = r_wr_g;
  assign o_wr_b       = r_wr_b;
  assign o_busy       = r_busy;
  assign o_clear_done = r_clear_done;
endmodule
